// File: rtl/loop_nest_counter_pkg.sv
// loop_nest_pkg: shared state type, default widths and packed-field helper for loop_nest_counter
package loop_nest_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NLEVELS_DEF = 2;
  localparam int IDX_W_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int PACK_W = 1024;
  function automatic logic [63:0] field(input logic [PACK_W-1:0] vec, input int k, input int w);
    logic [PACK_W-1:0] s;
    s = vec >> (k * w);
    return s[63:0] & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/loop_nest_counter_if.sv
// loop_nest_counter_if: start/bound control and indexed tuple handshake between driver and counter
interface loop_nest_counter_if import loop_nest_pkg::*; #(
  parameter int NLEVELS = NLEVELS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic start;
  logic [NLEVELS*IDX_W-1:0] bound;
  logic idx_valid;
  logic idx_ready;
  logic [NLEVELS*IDX_W-1:0] idx;
  logic [NLEVELS-1:0] idx_last;
  logic busy;
  logic done;
  logic [CNT_W-1:0] count;
  modport master (output start, bound, idx_ready, input idx_valid, idx, idx_last, busy, done, count);
  modport slave (input start, bound, idx_ready, output idx_valid, idx, idx_last, busy, done, count);
endinterface

// File: rtl/loop_nest_counter_loop_level.sv
// loop_level: one loop index with clear, carry-in advance, wrap at bound-1 and carry-out
module loop_level import loop_nest_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             cin_i,
  input  logic [IDX_W-1:0] bound_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             cout_o,
  output logic             last_o
);
  logic [IDX_W-1:0] idx_q;
  assign idx_o = idx_q;
  // a zero bound never reports last, so bound-1 never underflows into a match
  assign last_o = (bound_i != '0) && (idx_q == bound_i - IDX_W'(1));
  assign cout_o = cin_i & last_o;
  always_ff @(posedge clk) begin
    if (reset || clr_i) idx_q <= '0;
    else if (cin_i) idx_q <= last_o ? '0 : idx_q + IDX_W'(1);
  end
endmodule

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: N-level nested index generator with valid/ready output, start/done and tuple count
module loop_nest_counter import loop_nest_pkg::*; #(
  parameter int NLEVELS = NLEVELS_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic reset,
  loop_nest_counter_if.slave bus
);
  localparam int BW = NLEVELS * IDX_W;
  state_e state_q;
  logic valid_q, busy_q, done_q;
  logic [CNT_W-1:0] count_q;
  logic [BW-1:0] bound_q, idx;
  logic hs, clr;
  logic [NLEVELS:0] carry;
  logic [NLEVELS-1:0] last, zero;
  assign hs = valid_q & bus.idx_ready;
  assign clr = (state_q == IDLE) & bus.start;
  assign carry[0] = hs;
  genvar k;
  generate
    for (k = 0; k < NLEVELS; k++) begin : g_lvl
      assign zero[k] = IDX_W'(field(PACK_W'(bus.bound), k, IDX_W)) == '0;
      loop_level #(.IDX_W(IDX_W)) u_level (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .cin_i  (carry[k]),
        .bound_i(bound_q[k*IDX_W +: IDX_W]),
        .idx_o  (idx[k*IDX_W +: IDX_W]),
        .cout_o (carry[k+1]),
        .last_o (last[k])
      );
    end
  endgenerate
  assign bus.idx = idx;
  assign bus.idx_valid = valid_q;
  assign bus.idx_last = valid_q ? last : '0;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.count = count_q;
  // carry out of the outermost level is exactly the handshake on the final tuple
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      count_q <= '0;
      bound_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          bound_q <= bus.bound;
          count_q <= '0;
          valid_q <= ~|zero;
          busy_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (hs) count_q <= count_q + CNT_W'(1);
          if (!valid_q || carry[NLEVELS]) begin
            valid_q <= 1'b0;
            done_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
